seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the 16-bit display word from the shower-path 4:1 data selector and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Latches the word once per frame into a shadow register so a scan never shows digits from two different words.
- Scans one hex digit per refresh slot.
- Optionally blanks leading zeros.

Parameters:
- DIV_MAX, 50000, clock cycles per digit slot; legal range 1 to 2^20.
- LZB, 0, 1 enables leading-zero blanking; digit 0 is never blanked.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  display enable; 0 freezes the scan and blanks the outputs.
- data_in  input  16  word to display; digit k = data_in[4k+3:4k].
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held at 1 (off).
- frame_start  output  1  one-cycle pulse on the cycle shadow loads data_in.

Behaviour:
- Reset:
  - div_cnt=0, idx=0, shadow=16'h0000, an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - Applying rst mid-scan restores these values on the next edge.
- Divider:
  - div_cnt counts 0..DIV_MAX-1 while en=1.
  - tick = en && (div_cnt==DIV_MAX-1); div_cnt returns to 0 on tick.
  - With DIV_MAX=1, tick is asserted on every enabled cycle.
- Digit index:
  - On tick, idx increments: 0->1->2->3->0.
  - On the tick where idx wraps 3->0, shadow<=data_in and frame_start=1 for that following cycle only.
- First load: on the first enabled cycle after reset (flag first=1), shadow<=data_in, frame_start pulses and first clears. The display therefore shows live data without waiting a full frame.
- en=0:
  - div_cnt, idx and shadow hold.
  - Next edge: an=4'b1111, seg=7'h7F.
  - When en returns to 1, the scan resumes from the held div_cnt/idx.
- Output registers:
  - an and seg are registered from the current idx and shadow, so they lag idx by one cycle.
  - an = ~(4'b0001<<idx).
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (LZB=1):
  - Digit k (k>=1) is blanked (seg=7'h7F, anode still driven) when shadow[15:4k]==0.
  - Digit 0 always shows, so 0x0000 displays "0".
- data_in changes mid-frame have no effect until the next frame load.
- One output anode at most is low in any cycle.

Test Plan:
- Reset/first load:
  - Setup: DIV_MAX=4, rst high 3 cycles, data_in=16'h1234, en=1.
  - Required: frame_start pulses on the 1st cycle after rst falls.
  - Required: an sequence 1110,1101,1011,0111, each held 4 cycles.
  - Required: seg sequence 0011001(4), 0110000(3), 0100100(2), 1111001(1).
- Tear-free update:
  - Stimulus: change data_in to 16'hABCD while idx=1.
  - Required: digits 2,3 still show 2,1.
  - Required: frame_start pulses when idx wraps to 0; the next frame shows d,C,b,A.
- Enable freeze:
  - Stimulus: drop en for 10 cycles mid-slot at idx=2.
  - Required: an=1111, seg=1111111 throughout.
  - Required: on re-enable, idx=2 resumes with the remaining div_cnt count.
- Leading-zero blank:
  - Setup: LZB=1, data_in=16'h0050.
  - Required: digits 3,2 show seg=1111111; digit 1 shows 0010010; digit 0 shows 1000000.
  - Stimulus: data_in=16'h0000.
  - Required: only digit 0 shows 1000000.
- Reset mid-operation:
  - Stimulus: assert rst at idx=3, div_cnt=2.
  - Required: next edge an=1111, seg=1111111, shadow=0.
  - Required: after release, the sequence restarts at idx=0 with a fresh load.
- DIV_MAX=1 boundary:
  - Required: idx advances every cycle.
  - Required: frame_start every 4 cycles.
  - Required: no cycle has two anodes low.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Drives a 4-digit, common-anode, time-multiplexed seven-segment display from
// the 16-bit display word of the shower-path 4:1 data selector. One hex digit
// is shown per refresh slot of DIV_MAX clock cycles. The input word is copied
// into a shadow register once per frame, so one scan never mixes digits from
// two different words.
//
// Parameters
//   DIV_MAX : clock cycles per digit slot, 1 .. 2^20.
//   LZB     : 1 blanks leading zeros. Digit 0 is never blanked.
//
// Ports
//   clk         : system clock. All state updates on its rising edge.
//   rst         : synchronous reset, active-high.
//   en          : display enable. 0 freezes the scan and blanks the outputs.
//   data_in     : word to display. Digit k is data_in[4k+3:4k].
//   an          : digit anodes, active-low. an[0] is the rightmost digit.
//   seg         : segments {g,f,e,d,c,b,a}, active-low.
//   dp          : decimal point, active-low. Always off (1).
//   frame_start : one-cycle pulse after the edge on which the shadow loads.
//
// Timing
//   an/seg are registered from the current idx and shadow, so they lag idx by
//   one cycle. At most one anode is low in any cycle.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned DIV_MAX = 50000,
  parameter int unsigned LZB     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  // The divider needs at least one bit, even when DIV_MAX is 1.
  localparam int unsigned CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_MAX - 1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          first;

  // Next-state values
  logic [CW-1:0] div_cnt_d;
  logic [1:0]    idx_d;
  logic [15:0]   shadow_d;
  logic          first_d;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          frame_start_d;

  // Scan control
  logic          tick;
  logic          wrap;
  logic          load;

  // Display path
  logic [15:0]   disp_word;
  logic [3:0]    nib;
  logic [6:0]    seg_code;
  logic [3:0]    blank;

  // ---------------------------------------------------------------------------
  // Divider tick and frame-load conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    tick = en && (div_cnt == DIV_LAST);
    wrap = tick && (idx == 2'd3);
    // The first enabled cycle after reset loads immediately, so live data
    // appears without waiting a full frame.
    load = en && (first || wrap);
  end

  // ---------------------------------------------------------------------------
  // Word being displayed this cycle.
  // On the first-load cycle the shadow still holds the reset value, so the
  // digit-0 output registered on that same edge is taken from data_in.
  // This keeps the first slot showing the new word for its full length.
  // On a wrap load the outgoing digit 3 still comes from the old shadow,
  // which is what keeps each frame tear-free.
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_word = shadow;
    if (en && first) begin
      disp_word = data_in;
    end
  end

  // Nibble select for the current digit
  always_comb begin
    nib = 4'h0;
    case (idx)
      2'd0: nib = disp_word[3:0];
      2'd1: nib = disp_word[7:4];
      2'd2: nib = disp_word[11:8];
      2'd3: nib = disp_word[15:12];
      default: nib = 4'h0;
    endcase
  end

  // Hex to seven-segment, active-low, {g,f,e,d,c,b,a}
  always_comb begin
    seg_code = 7'h7F;
    case (nib)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      4'hF: seg_code = 7'b0001110;
      default: seg_code = 7'h7F;
    endcase
  end

  // Leading-zero mask.
  // Digit k (k >= 1) is a leading zero when every nibble from k upward is
  // zero. Digit 0 always shows, so an all-zero word still displays "0".
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_word[15:12] == 4'h0);
    blank[2] = (disp_word[15:8]  == 8'h00);
    blank[1] = (disp_word[15:4]  == 12'h000);
    blank[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // With en low everything holds and the outputs blank, so re-enabling
  // resumes the scan from the held slot and divider count.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_d     = div_cnt;
    idx_d         = idx;
    shadow_d      = shadow;
    first_d       = first;
    an_d          = 4'b1111;
    seg_d         = 7'h7F;
    frame_start_d = 1'b0;

    if (en) begin
      if (tick) begin
        div_cnt_d = '0;
        idx_d     = idx + 2'd1;
      end else begin
        div_cnt_d = div_cnt + 1'b1;
      end

      if (load) begin
        shadow_d = data_in;
      end
      first_d       = 1'b0;
      frame_start_d = load;

      // Exactly one anode low per enabled cycle.
      an_d = ~(4'b0001 << idx);
      // A blanked digit keeps its anode driven with all segments off.
      if ((LZB != 0) && blank[idx]) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = seg_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      first       <= 1'b1;
      an          <= 4'b1111;
      seg         <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_d;
      idx         <= idx_d;
      shadow      <= shadow_d;
      first       <= first_d;
      an          <= an_d;
      seg         <= seg_d;
      frame_start <= frame_start_d;
    end
  end

  // The decimal point is never used on this display.
  assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver. Three instances are used:
//   u_main : DIV_MAX=4, LZB=0  (reset, first load, tear-free, freeze, reset)
//   u_lzb  : DIV_MAX=4, LZB=1  (leading-zero blanking)
//   u_fast : DIV_MAX=1, LZB=0  (one slot per cycle)
// Outputs are sampled 1 ns after each rising edge. Inputs change at the same
// point, so they are seen on the following edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_m, en_m;
  logic [15:0] data_m;
  logic [3:0]  an_m;
  logic [6:0]  seg_m;
  logic        dp_m, fs_m;

  logic        rst_l, en_l;
  logic [15:0] data_l;
  logic [3:0]  an_l;
  logic [6:0]  seg_l;
  logic        dp_l, fs_l;

  logic        rst_f, en_f;
  logic [15:0] data_f;
  logic [3:0]  an_f;
  logic [6:0]  seg_f;
  logic        dp_f, fs_f;

  seg7_scan_driver #(.DIV_MAX(4), .LZB(0)) u_main (
    .clk(clk), .rst(rst_m), .en(en_m), .data_in(data_m),
    .an(an_m), .seg(seg_m), .dp(dp_m), .frame_start(fs_m)
  );

  seg7_scan_driver #(.DIV_MAX(4), .LZB(1)) u_lzb (
    .clk(clk), .rst(rst_l), .en(en_l), .data_in(data_l),
    .an(an_l), .seg(seg_l), .dp(dp_l), .frame_start(fs_l)
  );

  seg7_scan_driver #(.DIV_MAX(1), .LZB(0)) u_fast (
    .clk(clk), .rst(rst_f), .en(en_f), .data_in(data_f),
    .an(an_f), .seg(seg_f), .dp(dp_f), .frame_start(fs_f)
  );

  logic [12:0] obs_m, obs_l, obs_f;
  assign obs_m = {an_m, seg_m, dp_m, fs_m};
  assign obs_l = {an_l, seg_l, dp_l, fs_l};
  assign obs_f = {an_f, seg_f, dp_f, fs_f};

  // ---------------------------------------------------------------------------
  // Hand-written expected tables (index = digit / slot number)
  // ---------------------------------------------------------------------------
  logic [3:0] an_slot   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // 0x1234 : 4,3,2,1
  logic [6:0] seg_1234  [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  // 0xABCD : D,C,b,A
  logic [6:0] seg_abcd  [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
  // 0x6E9F : F,9,E,6
  logic [6:0] seg_6e9f  [4] = '{7'b0001110, 7'b0010000, 7'b0000110, 7'b0000010};
  // 0x0050 with blanking : 0,5,blank,blank
  logic [6:0] seg_lzb50 [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
  // 0x0000 with blanking : 0,blank,blank,blank
  logic [6:0] seg_lzb00 [4] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
  // 0x8C03 : 3,0,C,8
  logic [6:0] seg_8c03  [4] = '{7'b0110000, 7'b1000000, 7'b1000110, 7'b0000000};

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [12:0] ev(input logic [3:0] a, input logic [6:0] s,
                                     input logic f);
    return {a, s, 1'b1, f};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs,
                       input logic [12:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                tag, obs[12:9], obs[8:2], obs[1], obs[0],
                exp[12:9], exp[8:2], exp[1], exp[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_m = 1'b1; en_m = 1'b0; data_m = 16'h0000;
    rst_l = 1'b1; en_l = 1'b0; data_l = 16'h0000;
    rst_f = 1'b1; en_f = 1'b0; data_f = 16'h0000;

    // Reset held for three cycles.
    repeat (3) step();
    check("main_reset", obs_m, ev(4'b1111, 7'h7F, 1'b0));

    // First load of 0x1234. Data changes to 0xABCD while idx=1 (cycle 6);
    // digits 2,3 of this frame must still show 2,1.
    rst_m = 1'b0; en_m = 1'b1; data_m = 16'h1234;
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("frame1_c%0d", c), obs_m,
            ev(an_slot[(c-1)/4], seg_1234[(c-1)/4], (c == 1) || (c == 16)));
      if (c == 6) data_m = 16'hABCD;
    end

    // Second frame shows the new word.
    for (int c = 17; c <= 32; c++) begin
      step();
      check($sformatf("frame2_c%0d", c), obs_m,
            ev(an_slot[(c-17)/4], seg_abcd[(c-17)/4], c == 32));
    end

    // Third frame up to the second cycle of slot 2.
    for (int c = 33; c <= 42; c++) begin
      step();
      check($sformatf("frame3_c%0d", c), obs_m,
            ev(an_slot[(c-33)/4], seg_abcd[(c-33)/4], 1'b0));
    end

    // Freeze for 10 cycles mid-slot at idx=2.
    en_m = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("freeze_c%0d", c), obs_m, ev(4'b1111, 7'h7F, 1'b0));
    end

    // Resume: two remaining cycles of slot 2, then slot 3.
    en_m = 1'b1;
    step(); check("resume_s2a", obs_m, ev(an_slot[2], seg_abcd[2], 1'b0));
    step(); check("resume_s2b", obs_m, ev(an_slot[2], seg_abcd[2], 1'b0));
    step(); check("resume_s3a", obs_m, ev(an_slot[3], seg_abcd[3], 1'b0));
    step(); check("resume_s3b", obs_m, ev(an_slot[3], seg_abcd[3], 1'b0));

    // Now idx=3, div_cnt=2: reset mid-scan.
    rst_m = 1'b1; data_m = 16'h6E9F;
    step(); check("midrst_1", obs_m, ev(4'b1111, 7'h7F, 1'b0));
    step(); check("midrst_2", obs_m, ev(4'b1111, 7'h7F, 1'b0));

    // Restart at idx=0 with a fresh load.
    rst_m = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("restart_c%0d", c), obs_m,
            ev(an_slot[(c-1)/4], seg_6e9f[(c-1)/4], (c == 1) || (c == 16)));
    end

    // Leading-zero blanking on 0x0050, then 0x0000 from the next frame.
    check("lzb_reset", obs_l, ev(4'b1111, 7'h7F, 1'b0));
    rst_l = 1'b0; en_l = 1'b1; data_l = 16'h0050;
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("lzb50_c%0d", c), obs_l,
            ev(an_slot[(c-1)/4], seg_lzb50[(c-1)/4], (c == 1) || (c == 16)));
      if (c == 2) data_l = 16'h0000;
    end
    for (int c = 17; c <= 32; c++) begin
      step();
      check($sformatf("lzb00_c%0d", c), obs_l,
            ev(an_slot[(c-17)/4], seg_lzb00[(c-17)/4], c == 32));
    end

    // DIV_MAX=1: one slot per cycle, frame_start every fourth cycle.
    check("fast_reset", obs_f, ev(4'b1111, 7'h7F, 1'b0));
    rst_f = 1'b0; en_f = 1'b1; data_f = 16'h8C03;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("fast_c%0d", c), obs_f,
            ev(an_slot[(c-1)%4], seg_8c03[(c-1)%4], (c == 1) || (c % 4 == 0)));
      check($sformatf("fast_onehot_c%0d", c),
            {12'b0, ($countones(~an_f) <= 1)}, 13'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
